// File: rtl/csc_col_rd.sv
// Column reader for the CSC sparse channel matrix: it fetches col_ptr[col] and col_ptr[col+1],
// then streams each nonzero (row, value) of that column out over a valid/ready handshake.
module csc_col_rd #(
  parameter  int MAT_RANK = 256,
  parameter  int NNZ_MAX  = 1024,
  parameter  int DATA_W   = 32,
  localparam int ROW_W    = $clog2(MAT_RANK),
  localparam int PTR_W    = $clog2(NNZ_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [ROW_W:0]    req_col,
  output logic              ptr_rd,
  output logic [ROW_W:0]    ptr_addr,
  input  logic [PTR_W-1:0]  ptr_data,
  output logic              ent_rd,
  output logic [PTR_W-1:0]  ent_addr,
  input  logic [ROW_W-1:0]  ent_row,
  input  logic [DATA_W-1:0] ent_val_r,
  input  logic [DATA_W-1:0] ent_val_i,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [ROW_W-1:0]  out_row,
  output logic [ROW_W-1:0]  out_col,
  output logic [DATA_W-1:0] out_val_r,
  output logic [DATA_W-1:0] out_val_i,
  output logic              out_last,
  output logic              col_done,
  output logic              col_err
);

  typedef enum logic [2:0] {IDLE, P0, P1, P2, RD, LD, OUT, DONE} state_t;

  localparam logic [ROW_W:0]   RANK_LIM = (ROW_W + 1)'(MAT_RANK);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NNZ_MAX);

  state_t           state;
  logic [ROW_W:0]   col;
  logic [PTR_W-1:0] beg_ptr;
  logic [PTR_W-1:0] end_ptr;
  logic [PTR_W-1:0] cur;

  // Every output is a register; strobes and pulses default low and are set
  // on the edge that enters the state in which they must be visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      beg_ptr   <= '0;
      end_ptr   <= '0;
      cur       <= '0;
      req_rdy   <= 1'b0;
      ptr_rd    <= 1'b0;
      ptr_addr  <= '0;
      ent_rd    <= 1'b0;
      ent_addr  <= '0;
      out_vld   <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_val_r <= '0;
      out_val_i <= '0;
      out_last  <= 1'b0;
      col_done  <= 1'b0;
      col_err   <= 1'b0;
    end else begin
      ptr_rd   <= 1'b0;
      ent_rd   <= 1'b0;
      col_done <= 1'b0;
      col_err  <= 1'b0;
      case (state)
        IDLE: begin
          req_rdy <= 1'b1;
          if (req_vld && req_rdy) begin
            col     <= req_col;
            req_rdy <= 1'b0;
            if (req_col >= RANK_LIM) begin
              state    <= DONE;
              col_done <= 1'b1;
              col_err  <= 1'b1;
            end else begin
              state    <= P0;
              ptr_rd   <= 1'b1;
              ptr_addr <= req_col;
            end
          end
        end
        P0: begin
          // col is ROW_W+1 bits wide, so the last column reaches col_ptr[MAT_RANK].
          ptr_rd   <= 1'b1;
          ptr_addr <= col + (ROW_W + 1)'(1);
          state    <= P1;
        end
        P1: begin
          beg_ptr <= ptr_data;
          state   <= P2;
        end
        P2: begin
          end_ptr <= ptr_data;
          cur     <= beg_ptr;
          if (ptr_data == beg_ptr) begin
            state    <= DONE;
            col_done <= 1'b1;
          end else if (ptr_data < beg_ptr || ptr_data > PTR_MAX) begin
            state    <= DONE;
            col_done <= 1'b1;
            col_err  <= 1'b1;
          end else begin
            state    <= RD;
            ent_rd   <= 1'b1;
            ent_addr <= beg_ptr;
          end
        end
        RD: state <= LD;
        LD: begin
          out_row   <= ent_row;
          out_col   <= col[ROW_W-1:0];
          out_val_r <= ent_val_r;
          out_val_i <= ent_val_i;
          out_last  <= (cur + PTR_W'(1)) == end_ptr;
          out_vld   <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_rdy) begin
            out_vld <= 1'b0;
            cur     <= cur + PTR_W'(1);
            if (out_last) begin
              state    <= DONE;
              col_done <= 1'b1;
            end else begin
              state    <= RD;
              ent_rd   <= 1'b1;
              ent_addr <= cur + PTR_W'(1);
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          req_rdy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csc_col_rd.sv
// Scoreboard bench for csc_col_rd: stimulus queues expected beats and completions,
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_csc_col_rd;

  localparam int ROW_W = 8;
  localparam int PTR_W = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_vld;
  logic              req_rdy;
  logic [ROW_W:0]    req_col;
  logic              ptr_rd;
  logic [ROW_W:0]    ptr_addr;
  logic [PTR_W-1:0]  ptr_data;
  logic              ent_rd;
  logic [PTR_W-1:0]  ent_addr;
  logic [ROW_W-1:0]  ent_row;
  logic [31:0]       ent_val_r;
  logic [31:0]       ent_val_i;
  logic              out_vld;
  logic              out_rdy;
  logic [ROW_W-1:0]  out_row;
  logic [ROW_W-1:0]  out_col;
  logic [31:0]       out_val_r;
  logic [31:0]       out_val_i;
  logic              out_last;
  logic              col_done;
  logic              col_err;

  csc_col_rd dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_col(req_col),
    .ptr_rd(ptr_rd), .ptr_addr(ptr_addr), .ptr_data(ptr_data),
    .ent_rd(ent_rd), .ent_addr(ent_addr), .ent_row(ent_row),
    .ent_val_r(ent_val_r), .ent_val_i(ent_val_i),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_row(out_row), .out_col(out_col),
    .out_val_r(out_val_r), .out_val_i(out_val_i), .out_last(out_last),
    .col_done(col_done), .col_err(col_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models with one-cycle registered read
  logic [PTR_W-1:0] col_ptr_mem [0:256];
  logic [ROW_W-1:0] row_mem [0:1023];

  function automatic logic [31:0] fr(input int a);
    return 32'hA000_0000 | 32'(a);
  endfunction
  function automatic logic [31:0] fi(input int a);
    return 32'h5000_0000 + 32'(a * 3);
  endfunction

  always @(posedge clk) begin
    if (ptr_rd) ptr_data <= col_ptr_mem[ptr_addr];
    if (ent_rd) begin
      ent_row   <= row_mem[ent_addr[9:0]];
      ent_val_r <= fr(int'(ent_addr));
      ent_val_i <= fi(int'(ent_addr));
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic [7:0]  row;
    logic [7:0]  col;
    logic [31:0] vr;
    logic [31:0] vi;
    logic        last;
  } beat_t;

  typedef struct {
    int t; int lat; int err; int nptr; int nent; int fv; int pa0; int pa1; int le;
  } done_t;

  beat_t bq[$];
  done_t dq[$];

  // Monitor state
  int ptr_cnt = 0, ent_cnt = 0, first_vld = -1, pa0 = 0, pa1 = 0, last_ent = 0;
  bit hold = 0;
  logic [7:0]  held_row;
  logic [31:0] held_vr;
  logic        held_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      ptr_cnt = 0; ent_cnt = 0; first_vld = -1; hold = 0;
    end else begin
      if (ptr_rd) begin
        if (ptr_cnt == 0) pa0 = int'(ptr_addr); else pa1 = int'(ptr_addr);
        ptr_cnt++;
      end
      if (ent_rd) begin
        ent_cnt++;
        last_ent = int'(ent_addr);
      end
      if (out_vld && first_vld < 0) first_vld = cyc;
      if (hold && out_vld) begin
        check("hold_row", out_row, held_row);
        check("hold_val_r", out_val_r, held_vr);
        check("hold_last", out_last, held_last);
      end
      hold = out_vld && !out_rdy;
      held_row = out_row; held_vr = out_val_r; held_last = out_last;
      if (out_vld && out_rdy) begin
        if (bq.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          beat_t b;
          b = bq.pop_front();
          check("beat_row", out_row, b.row);
          check("beat_col", out_col, b.col);
          check("beat_val_r", out_val_r, b.vr);
          check("beat_val_i", out_val_i, b.vi);
          check("beat_last", out_last, b.last);
        end
      end
      if (col_done) begin
        if (dq.size() == 0) check("unexpected_done", 1, 0);
        else begin
          done_t d;
          d = dq.pop_front();
          check("done_latency", cyc - d.t, d.lat);
          check("done_err", col_err, d.err);
          check("ptr_reads", ptr_cnt, d.nptr);
          check("ent_reads", ent_cnt, d.nent);
          check("first_vld_lat", (first_vld < 0) ? -1 : first_vld - d.t, d.fv);
          if (d.nptr == 2) begin
            check("ptr_addr0", pa0, d.pa0);
            check("ptr_addr1", pa1, d.pa1);
          end
          if (d.nent > 0) check("last_ent_addr", last_ent, d.le);
        end
        ptr_cnt = 0; ent_cnt = 0; first_vld = -1;
      end
    end
  end

  task automatic push_beat(input int row, input int col, input int addr, input bit last);
    beat_t b;
    b.row = 8'(row); b.col = 8'(col); b.vr = fr(addr); b.vi = fi(addr); b.last = last;
    bq.push_back(b);
  endtask

  task automatic push_done(input int t, input int lat, input int err, input int nptr,
                           input int nent, input int fv, input int p0, input int p1, input int le);
    done_t d;
    d.t = t; d.lat = lat; d.err = err; d.nptr = nptr; d.nent = nent;
    d.fv = fv; d.pa0 = p0; d.pa1 = p1; d.le = le;
    dq.push_back(d);
  endtask

  // Called at posedge+#1; returns the accept cycle T.
  task automatic issue(input int col, output int t);
    int n = 0;
    while (!req_rdy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!req_rdy) check("req_rdy_wait", req_rdy, 1);
    req_vld = 1'b1;
    req_col = 9'(col);
    t = cyc;
    @(posedge clk); #1;
    req_vld = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((dq.size() != 0 || bq.size() != 0) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_done_q"}, dq.size(), 0);
    check({name, "_beat_q"}, bq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic col5_beats();
    push_beat(2, 5, 10, 0);
    push_beat(7, 5, 11, 0);
    push_beat(200, 5, 12, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int i = 0; i < 257; i++) col_ptr_mem[i] = '0;
    for (int i = 0; i < 1024; i++) row_mem[i] = 8'(i);
    col_ptr_mem[3] = 8;    col_ptr_mem[4] = 8;
    col_ptr_mem[5] = 10;   col_ptr_mem[6] = 13;
    col_ptr_mem[9] = 50;   col_ptr_mem[10] = 40;
    col_ptr_mem[255] = 1020; col_ptr_mem[256] = 1024;
    row_mem[10] = 2; row_mem[11] = 7; row_mem[12] = 200;
    row_mem[1020] = 0; row_mem[1021] = 17; row_mem[1022] = 128; row_mem[1023] = 255;

    rst_n = 1'b0; req_vld = 1'b0; req_col = '0; out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_ptr_rd", ptr_rd, 0);
    check("rst_col_done", col_done, 0);
    check("rst_out_row", out_row, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req_rdy", req_rdy, 1);

    // Three-entry column, no backpressure
    col5_beats();
    issue(5, t);
    push_done(t, 13, 0, 2, 3, 6, 5, 6, 12);
    drain("col5");

    // Empty column
    issue(3, t);
    push_done(t, 4, 0, 2, 0, -1, 3, 4, 0);
    drain("col3");

    // Backpressure on the second beat for four cycles
    col5_beats();
    issue(5, t);
    push_done(t, 17, 0, 2, 3, 6, 5, 6, 12);
    wait_until(t + 9);
    out_rdy = 1'b0;
    wait_until(t + 13);
    out_rdy = 1'b1;
    drain("col5_bp");

    // Last column reaches col_ptr[256]
    push_beat(0, 255, 1020, 0);
    push_beat(17, 255, 1021, 0);
    push_beat(128, 255, 1022, 0);
    push_beat(255, 255, 1023, 1);
    issue(255, t);
    push_done(t, 16, 0, 2, 4, 6, 255, 256, 1023);
    drain("col255");

    // Out-of-range column and inverted pointers
    issue(256, t);
    push_done(t, 1, 1, 0, 0, -1, 0, 0, 0);
    drain("col256");
    issue(9, t);
    push_done(t, 4, 1, 2, 0, -1, 9, 10, 0);
    drain("col9");

    // Reset during the second OUT of a three-entry column
    push_beat(2, 5, 10, 0);
    issue(5, t);
    wait_until(t + 8);
    out_rdy = 1'b0;
    wait_until(t + 9);
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midrst_out_vld", out_vld, 0);
      check("midrst_req_rdy", req_rdy, 0);
      check("midrst_col_done", col_done, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_rdy = 1'b1;
    check("midrst_beat_q", bq.size(), 0);
    @(posedge clk); #1;
    check("midrst_req_rdy_after", req_rdy, 1);

    col5_beats();
    issue(5, t);
    push_done(t, 13, 0, 2, 3, 6, 5, 6, 12);
    drain("col5_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csc_col_rd.md
# csc_col_rd

Column reader for the sparse channel matrix that the CSC storage stage writes. Given a column index, it reads the column-pointer memory and then the row-index/value memory, and streams the column's nonzero complex entries out over a valid/ready handshake. It is the read-side counterpart of the CSC writer and feeds the downstream equaliser/matrix-vector stage.

## Interface
- MAT_RANK, 256, matrix dimension (OFDM_SYM_NUM*SUBCAR_NUM); ROW_W = clog2(MAT_RANK)
- NNZ_MAX, 1024, nonzero capacity; PTR_W = clog2(NNZ_MAX+1)
- DATA_W, 32, width of each real/imag value
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  1  column request valid
- req_rdy  out  1  high only in IDLE
- req_col  in  ROW_W+1  requested column index
- ptr_rd / ptr_addr  out  1 / ROW_W+1  col_ptr memory read strobe/address; data 1 cycle later
- ptr_data  in  PTR_W  col_ptr[ptr_addr] from previous cycle's read
- ent_rd / ent_addr  out  1 / PTR_W  entry memory read strobe/address; data 1 cycle later
- ent_row  in  ROW_W  row index of entry
- ent_val_r / ent_val_i  in  DATA_W  entry real/imag value
- out_vld  out  1  entry valid
- out_rdy  in  1  downstream accept
- out_row / out_col  out  ROW_W  entry row / column
- out_val_r / out_val_i  out  DATA_W  entry value
- out_last  out  1  final entry of column (qualified by out_vld)
- col_done  out  1  one-cycle pulse at end of each request
- col_err  out  1  one-cycle pulse with col_done on a bad request

## Operation
- States: IDLE, P0, P1, P2, RD, LD, OUT, DONE.
- IDLE: req_rdy=1. On req_vld: latch req_col. If req_col >= MAT_RANK -> DONE with err; else -> P0.
- P0: ptr_rd=1, ptr_addr=col -> P1.
- P1: ptr_rd=1, ptr_addr=col+1; latch beg=ptr_data -> P2.
- P2: latch end=ptr_data; cur=beg. end==beg -> DONE (empty, no err). end<beg or end>NNZ_MAX -> DONE with err. Else -> RD.
- RD: ent_rd=1, ent_addr=cur -> LD.
- LD: register ent_row, ent_val_r/i into out regs; out_col=col; out_last=(cur+1==end) -> OUT.
- OUT: out_vld=1; outputs held stable until out_rdy. On out_rdy: cur=cur+1; last -> DONE, else -> RD.
- DONE: col_done=1 (col_err=1 if flagged) -> IDLE.
- Read strobes are low in every state not listed above; addresses hold their last value.
- Arithmetic: cur, beg, end unsigned PTR_W; col+1 computed in ROW_W+1 bits so col=MAT_RANK-1 addresses col_ptr[MAT_RANK] without wrap.

## Timing
- Reset: state IDLE; req_rdy=1 after reset release; every other output 0; internal regs 0.
- Request accepted in cycle T (req_vld & req_rdy). P0 runs at T+1, P1 at T+2, P2 at T+3, RD at T+4, and the first out_vld at T+6.
- Per entry with out_rdy held high: RD, LD, OUT = 3 cycles/entry. A column of N>0 entries finishes with col_done at T+4+3N.
- Empty column: col_done at T+4, no out_vld. Out-of-range column: col_done+col_err at T+1, with no memory reads.
- Backpressure: each cycle out_rdy is low in OUT adds one cycle. out_* are not allowed to change while out_vld=1 and out_rdy=0.
- req_vld outside IDLE is ignored; the requester must hold the request until req_rdy.
- Reset asserted mid-column: immediate return to IDLE with all outputs 0. The partial column is discarded and there is no col_done.

## Test plan
- col_ptr[5]=10, col_ptr[6]=13, entries 10..12 rows {2,7,200}. Request col 5 with out_rdy=1 -> 3 beats: rows 2, 7, 200, out_col=5, out_last only on row 200. First out_vld at T+6, col_done at T+13.
- col_ptr[3]=col_ptr[4]=8. Request col 3 -> no ent_rd, no out_vld, col_done at T+4, col_err=0.
- Same setup as the first case with out_rdy low for 4 cycles on the 2nd beat -> row 7 and its value held stable the whole time; col_done delayed by 4 cycles to T+17.
- Request col 255 with col_ptr[255]=1020, col_ptr[256]=1024 -> ptr_addr 255 then 256, 4 beats, last ent_addr=1023.
- Request col 256 -> col_done and col_err at T+1, no ptr_rd. Separately, col_ptr[9]=50, col_ptr[10]=40 -> col_err at T+4.
- Assert rst_n low during the 2nd OUT of a 3-entry column -> out_vld=0 and req_rdy=0 while in reset, no col_done. After release, req_rdy=1 and a new request completes normally.
